// File: rtl/mips_mem_pkg.sv
// Shared types and span helpers for the MEM-stage store buffer.
// Spans are half-open byte ranges [lo, hi) carried one bit wider than the
// address so a range touching the top of the address space never wraps.
package mips_mem_pkg;

   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;

   localparam int unsigned WORD_SPAN   = 4;
   localparam int unsigned DOUBLE_SPAN = 8;
   localparam int unsigned BYTE_OFS    = 3;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
      logic [SB_DATA_W-1:0] data2;
      logic                 is_byte;
      logic                 is_double;
   } sb_entry_t;

   // A byte store only touches the last byte of its word.
   function automatic logic [SB_ADDR_W:0] span_lo(input logic [SB_ADDR_W-1:0] addr,
                                                  input logic                 is_byte);
      logic [SB_ADDR_W:0] ofs;
      ofs = is_byte ? (SB_ADDR_W+1)'(BYTE_OFS) : '0;
      return {1'b0, addr} + ofs;
   endfunction

   // Byte and word accesses both end at addr+4; doubles end at addr+8.
   function automatic logic [SB_ADDR_W:0] span_hi(input logic [SB_ADDR_W-1:0] addr,
                                                  input logic                 is_double);
      logic [SB_ADDR_W:0] len;
      len = is_double ? (SB_ADDR_W+1)'(DOUBLE_SPAN) : (SB_ADDR_W+1)'(WORD_SPAN);
      return {1'b0, addr} + len;
   endfunction

endpackage

// File: rtl/sb_range_overlap.sv
// Combinational overlap test of two half-open ranges [a_lo,a_hi) and [b_lo,b_hi).
module sb_range_overlap #(
   parameter int W = 33
) (
   input  logic [W-1:0] a_lo,
   input  logic [W-1:0] a_hi,
   input  logic [W-1:0] b_lo,
   input  logic [W-1:0] b_hi,
   output logic         overlap
);

   assign overlap = (a_lo < b_hi) && (b_lo < a_hi);

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: retired stores queue in a FIFO and drain one per
// cycle onto the DataMemory port. Loads win the port; a load overlapping any
// queued store stalls until the overlapping entries (and older ones) drain.
// Entry fields use the package widths, so ADDR_W/DATA_W must match them.
module store_buffer
   import mips_mem_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   input  logic [DATA_W-1:0]          st_data2,
   input  logic                       st_byte,
   input  logic                       st_double,
   input  logic                       ld_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   input  logic                       ld_double,
   input  logic                       drain_en,
   output logic                       stall,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic [DATA_W-1:0]          mem_wdata2,
   output logic                       mem_memW,
   output logic                       mem_memR,
   output logic                       mem_storeByte,
   output logic                       mem_double
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   sb_entry_t        entry_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [DEPTH-1:0] hit;
   logic [ADDR_W:0]  ld_lo, ld_hi;
   logic             conflict, ld_grant, fifo_empty, fifo_full;
   logic             pop, push, stall_int;
   sb_entry_t        head_e, new_e;

   assign ld_lo = span_lo(ld_addr, 1'b0);
   assign ld_hi = span_hi(ld_addr, ld_double);

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [ADDR_W:0] e_lo, e_hi;
      logic            ov;
      assign e_lo = span_lo(entry_q[i].addr, entry_q[i].is_byte);
      assign e_hi = span_hi(entry_q[i].addr, entry_q[i].is_double);
      sb_range_overlap #(.W(ADDR_W+1)) u_ovl (
         .a_lo    (ld_lo),
         .a_hi    (ld_hi),
         .b_lo    (e_lo),
         .b_hi    (e_hi),
         .overlap (ov)
      );
      assign hit[i] = valid_q[i] & ov;
   end

   assign conflict   = ld_valid & (|hit);
   assign ld_grant   = ld_valid & ~conflict;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign pop        = ~ld_grant & ~fifo_empty & drain_en;
   // Store together with load is illegal: the load is served, the store waits.
   assign stall_int  = conflict | (st_valid & ld_valid) | (st_valid & fifo_full & ~pop);
   assign push       = st_valid & ~stall_int;
   assign head_e     = entry_q[head_q];

   // Pack the incoming store into an entry.
   always_comb begin
      new_e           = '0;
      new_e.addr      = st_addr;
      new_e.data      = st_data;
      new_e.data2     = st_data2;
      new_e.is_byte   = st_byte;
      new_e.is_double = st_double;
   end

   // Pointer, valid and count next-state; push after pop so a full-FIFO
   // push into the slot being freed leaves it valid.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Control state, cleared asynchronously so queued stores are discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Entry payload storage; meaningless unless the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (push) entry_q[tail_q] <= new_e;
   end

   // DataMemory port arbitration: load first, then drain, else idle at zero.
   always_comb begin
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_wdata2    = '0;
      mem_memW      = 1'b0;
      mem_memR      = 1'b0;
      mem_storeByte = 1'b0;
      mem_double    = 1'b0;
      if (!reset) begin
         if (ld_grant) begin
            mem_memR   = 1'b1;
            mem_addr   = ld_addr;
            mem_double = ld_double;
         end else if (pop) begin
            mem_memW      = 1'b1;
            mem_addr      = head_e.addr;
            mem_wdata     = head_e.data;
            mem_wdata2    = head_e.data2;
            mem_storeByte = head_e.is_byte;
            mem_double    = head_e.is_double;
         end
      end
   end

   assign stall = ~reset & stall_int;
   assign empty = fifo_empty;
   assign count = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run against a queue-level reference model and a byte-addressed memory.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        st_valid, st_byte, st_double, ld_valid, ld_double, drain_en;
   logic [31:0] st_addr, st_data, st_data2, ld_addr;
   logic        stall, empty, mem_memW, mem_memR, mem_storeByte, mem_double;
   logic [2:0]  count;
   logic [31:0] mem_addr, mem_wdata, mem_wdata2;

   int checks = 0;
   int failures = 0;

   logic [7:0] dut_mem [longint];
   logic [7:0] ref_mem [longint];

   typedef struct {
      longint      addr;
      logic [31:0] d;
      logic [31:0] d2;
      bit          b;
      bit          dbl;
   } st_t;
   st_t q[$];

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_data2(st_data2),
      .st_byte(st_byte), .st_double(st_double),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_double(ld_double),
      .drain_en(drain_en),
      .stall(stall), .empty(empty), .count(count),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata2(mem_wdata2),
      .mem_memW(mem_memW), .mem_memR(mem_memR),
      .mem_storeByte(mem_storeByte), .mem_double(mem_double)
   );

   task automatic put(input bit to_ref, input longint a, input logic [7:0] v);
      if (to_ref) ref_mem[a] = v;
      else        dut_mem[a] = v;
   endtask

   // Big-endian DataMemory semantics: byte store writes addr+3 only.
   task automatic wr_bytes(input bit to_ref, input longint a, input logic [31:0] d,
                           input logic [31:0] d2, input bit b, input bit dbl);
      if (b) put(to_ref, a + 3, d[7:0]);
      else begin
         for (int k = 0; k < 4; k++) put(to_ref, a + k, d[31-8*k -: 8]);
         if (dbl) for (int k = 0; k < 4; k++) put(to_ref, a + 4 + k, d2[31-8*k -: 8]);
      end
   endtask

   function automatic logic [7:0] rd(input longint a);
      return dut_mem.exists(a) ? dut_mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] rdata();
      longint a;
      a = longint'(mem_addr);
      return {rd(a), rd(a + 1), rd(a + 2), rd(a + 3)};
   endfunction

   // DataMemory stand-in driven purely by the DUT port.
   always @(posedge clk) begin
      if (!reset && mem_memW)
         wr_bytes(1'b0, longint'(mem_addr), mem_wdata, mem_wdata2, mem_storeByte, mem_double);
   end

   task automatic set_in(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [31:0] sd2, input bit sb, input bit sdb,
                         input bit lv, input logic [31:0] la, input bit ldb);
      st_valid = sv; st_addr = sa; st_data = sd; st_data2 = sd2;
      st_byte = sb; st_double = sdb;
      ld_valid = lv; ld_addr = la; ld_double = ldb;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      idle();
      drain_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      ref_mem.delete();
      dut_mem.delete();
      next_cycle();
   endtask

   task automatic test_reset();
      set_in(1, 32'h10, 32'h1, 0, 0, 0, 1, 32'h10, 0);
      drain_en = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({stall, mem_memW, mem_memR, mem_storeByte, mem_double} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {stall, mem_memW, mem_memR, mem_storeByte, mem_double});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_wdata2} !== 96'h0) begin
         failures++;
         $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, mem_wdata2});
      end
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         failures++;
         $display("FAIL reset_cnt empty=%b count=%0d want 1/0", empty, count);
      end
      idle();
      @(negedge clk);
      reset = 1'b0;
      next_cycle();
   endtask

   task automatic test_word_store();
      hard_reset();
      set_in(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (mem_memW !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL no_bypass memW=%b stall=%b want 0/0", mem_memW, stall);
      end
      next_cycle();
      idle();
      @(negedge clk);
      checks++;
      if (mem_memW !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL word_drain memW=%b addr=%h wdata=%h want 1/10/deadbeef",
                  mem_memW, mem_addr, mem_wdata);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({rd(16), rd(17), rd(18), rd(19)} !== 32'hDEADBEEF || empty !== 1'b1) begin
         failures++;
         $display("FAIL word_mem got=%h empty=%b want deadbeef/1",
                  {rd(16), rd(17), rd(18), rd(19)}, empty);
      end
   endtask

   task automatic test_full();
      hard_reset();
      drain_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'h100 + 32'(4*i), 32'h11110000 + 32'(i), 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         checks++;
         if (stall !== 1'b0) begin
            failures++;
            $display("FAIL fill_stall i=%0d got=%b want=0", i, stall);
         end
         next_cycle();
      end
      set_in(1, 32'h110, 32'h11110004, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (count !== 3'd4 || stall !== 1'b1) begin
         failures++;
         $display("FAIL full_stall count=%0d stall=%b want 4/1", count, stall);
      end
      next_cycle();
      drain_en = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_memW !== 1'b1 || mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL full_push_pop stall=%b memW=%b addr=%h want 0/1/100",
                  stall, mem_memW, mem_addr);
      end
      next_cycle();
      idle();
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 1) begin
            checks++;
            if (count !== 3'd4) begin
               failures++;
               $display("FAIL full_count got=%0d want=4", count);
            end
         end
         checks++;
         if (mem_memW !== 1'b1 || mem_addr !== 32'h100 + 32'(4*j) ||
             mem_wdata !== 32'h11110000 + 32'(j)) begin
            failures++;
            $display("FAIL fifo_order j=%0d memW=%b addr=%h wdata=%h", j, mem_memW,
                     mem_addr, mem_wdata);
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL full_empty got=%b want=1", empty);
      end
   endtask

   task automatic test_byte_conflict();
      hard_reset();
      drain_en = 1'b0;
      set_in(1, 32'h20, 32'h000000A5, 0, 1, 0, 0, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h20, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_memR !== 1'b0 || mem_memW !== 1'b0) begin
         failures++;
         $display("FAIL byte_conf_hold stall=%b memR=%b memW=%b want 1/0/0",
                  stall, mem_memR, mem_memW);
      end
      next_cycle();
      drain_en = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_memW !== 1'b1 || mem_storeByte !== 1'b1 || mem_addr !== 32'h20) begin
         failures++;
         $display("FAIL byte_drain stall=%b memW=%b sb=%b addr=%h want 1/1/1/20",
                  stall, mem_memW, mem_storeByte, mem_addr);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_memR !== 1'b1 || mem_addr !== 32'h20 || rdata() !== 32'h000000A5) begin
         failures++;
         $display("FAIL byte_load stall=%b memR=%b addr=%h rdata=%h want 0/1/20/000000a5",
                  stall, mem_memR, mem_addr, rdata());
      end
      idle();
   endtask

   task automatic test_load_priority();
      hard_reset();
      set_in(1, 32'h40, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h48, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_memR !== 1'b1 || mem_addr !== 32'h48 || mem_memW !== 1'b0) begin
         failures++;
         $display("FAIL ld_prio stall=%b memR=%b addr=%h memW=%b want 0/1/48/0",
                  stall, mem_memR, mem_addr, mem_memW);
      end
      next_cycle();
      idle();
      @(negedge clk);
      checks++;
      if (count !== 3'd1 || mem_memW !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL ld_prio_drain count=%0d memW=%b addr=%h wdata=%h", count, mem_memW,
                  mem_addr, mem_wdata);
      end
      next_cycle();
   endtask

   task automatic test_double_conflict();
      hard_reset();
      set_in(1, 32'h50, 32'h01020304, 32'h0A0B0C0D, 0, 1, 0, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h54, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_memW !== 1'b1 || mem_double !== 1'b1 || mem_wdata2 !== 32'h0A0B0C0D) begin
         failures++;
         $display("FAIL dbl_conf stall=%b memW=%b dbl=%b wdata2=%h", stall, mem_memW,
                  mem_double, mem_wdata2);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_memR !== 1'b1 || rdata() !== 32'h0A0B0C0D) begin
         failures++;
         $display("FAIL dbl_load stall=%b memR=%b rdata=%h want 0/1/0a0b0c0d",
                  stall, mem_memR, rdata());
      end
      idle();
   endtask

   task automatic test_boundaries();
      hard_reset();
      drain_en = 1'b0;
      set_in(1, 32'h60, 32'h1, 0, 0, 0, 0, 0, 0);
      next_cycle();
      set_in(1, 32'h00000000, 32'h2, 0, 0, 0, 0, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h5C, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_memR !== 1'b1) begin
         failures++;
         $display("FAIL edge_adjacent stall=%b memR=%b want 0/1", stall, mem_memR);
      end
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'h5D, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_memR !== 1'b0) begin
         failures++;
         $display("FAIL edge_touch stall=%b memR=%b want 1/0", stall, mem_memR);
      end
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 1);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_memR !== 1'b1 || mem_double !== 1'b1) begin
         failures++;
         $display("FAIL top_nowrap stall=%b memR=%b dbl=%b want 0/1/1", stall, mem_memR, mem_double);
      end
      next_cycle();
      set_in(1, 32'h70, 32'h3, 0, 0, 0, 1, 32'h80, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_memR !== 1'b1 || count !== 3'd2) begin
         failures++;
         $display("FAIL st_ld_both stall=%b memR=%b count=%0d want 1/1/2", stall, mem_memR, count);
      end
      next_cycle();
      idle();
      @(negedge clk);
      checks++;
      if (count !== 3'd2) begin
         failures++;
         $display("FAIL st_ld_nopush count=%0d want=2", count);
      end
      drain_en = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset_mid_drain();
      hard_reset();
      drain_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'h200 + 32'(4*i), 32'hA0B0C0D0 + 32'(i), 0, 0, 0, 0, 0, 0);
         next_cycle();
      end
      idle();
      drain_en = 1'b1;
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem_memW !== 1'b1 || mem_addr !== 32'h204 || count !== 3'd2) begin
         failures++;
         $display("FAIL mid_drain memW=%b addr=%h count=%0d want 1/204/2", mem_memW, mem_addr, count);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (mem_memW !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL async_reset memW=%b count=%0d empty=%b want 0/0/1", mem_memW, count, empty);
      end
      @(negedge clk);
      reset = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++;
      if ({rd(32'h200), rd(32'h201), rd(32'h202), rd(32'h203)} !== 32'hA0B0C0D0 ||
          {rd(32'h204), rd(32'h205), rd(32'h206), rd(32'h207)} !== 32'h0 ||
          {rd(32'h208), rd(32'h209), rd(32'h20A), rd(32'h20B)} !== 32'h0 || mem_memW !== 1'b0) begin
         failures++;
         $display("FAIL reset_discard m200=%h m204=%h memW=%b",
                  {rd(32'h200), rd(32'h201), rd(32'h202), rd(32'h203)},
                  {rd(32'h204), rd(32'h205), rd(32'h206), rd(32'h207)}, mem_memW);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(9) == 0) return 32'hFFFFFFF0 + 32'($urandom_range(15));
      return 32'($urandom_range(63));
   endfunction

   task automatic test_random();
      logic [104:0] exp_v, got_v;
      bit           conf, grant, pop, push, full;
      longint       la, lhi, lo, hi;
      int           r, kind, bad;
      hard_reset();
      for (int n = 0; n < 420; n++) begin
         if (n < 400) begin
            r = $urandom_range(99);
            kind = $urandom_range(2);
            set_in(r < 35 || (r >= 65 && r < 70), rand_addr(), $urandom, $urandom,
                   kind == 1, kind == 2, r >= 35 && r < 70, rand_addr(), $urandom_range(1) == 1);
            drain_en = ($urandom_range(4) != 0);
         end else begin
            idle();
            drain_en = 1'b1;
         end
         @(negedge clk);
         la = longint'(ld_addr);
         lhi = la + (ld_double ? 8 : 4);
         conf = 0;
         foreach (q[k]) begin
            lo = q[k].addr + (q[k].b ? 3 : 0);
            hi = q[k].addr + (q[k].dbl ? 8 : 4);
            if (ld_valid && la < hi && lo < lhi) conf = 1;
         end
         grant = ld_valid && !conf;
         pop = !grant && q.size() > 0 && drain_en;
         full = (q.size() == 4);
         push = st_valid && !(conf || ld_valid || (full && !pop));
         if (grant)
            exp_v = {1'b0 | st_valid, 1'b0, 1'b1, 1'b0, ld_double, ld_addr, 64'h0,
                     3'(q.size()), q.size() == 0};
         else if (pop)
            exp_v = {conf | (st_valid & ld_valid) | 1'b0, 1'b1, 1'b0, q[0].b, q[0].dbl,
                     q[0].addr[31:0], q[0].d, q[0].d2, 3'(q.size()), 1'b0};
         else
            exp_v = {conf | (st_valid & ld_valid) | (st_valid & full), 4'b0, 96'h0,
                     3'(q.size()), q.size() == 0};
         got_v = {stall, mem_memW, mem_memR, mem_storeByte, mem_double, mem_addr,
                  mem_wdata, mem_wdata2, count, empty};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL random_cycle n=%0d got=%h want=%h", n, got_v, exp_v);
         end
         @(posedge clk);
         if (pop) begin
            wr_bytes(1'b1, q[0].addr, q[0].d, q[0].d2, q[0].b, q[0].dbl);
            void'(q.pop_front());
         end
         if (push) q.push_back('{longint'(st_addr), st_data, st_data2, st_byte, st_double});
         #1;
      end
      bad = 0;
      foreach (ref_mem[a]) if (rd(a) !== ref_mem[a]) bad++;
      checks++;
      if (bad != 0 || dut_mem.size() != ref_mem.size() || q.size() != 0) begin
         failures++;
         $display("FAIL random_memory bad_bytes=%0d dut_n=%0d ref_n=%0d left=%0d want 0/equal/0",
                  bad, dut_mem.size(), ref_mem.size(), q.size());
      end
   endtask

   initial begin
      idle();
      drain_en = 1'b1;
      test_reset();
      test_word_store();
      test_full();
      test_byte_conflict();
      test_load_priority();
      test_double_conflict();
      test_boundaries();
      test_reset_mid_drain();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
